// File: rtl/layer_transfer_sequencer_if.sv
// layer_transfer_sequencer_if: source-read / destination-write memory bus
// between the transfer sequencer (master) and the two feature-map RAMs (slave).
interface layer_transfer_sequencer_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 16
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output wr_en,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/layer_transfer_sequencer.sv
// layer_transfer_sequencer: copies one NUM_CH x DIM x DIM feature-map volume
// from the layer-1 output RAM to the layer-2 input RAM, one read then one
// write per element (x fastest, then y, then ch), and pulses done when the
// final write is accepted.
// Optional feature: define LAYER_TRANSFER_RELU_EN to load ReLU(rd_data)
// into the data register (negative two's-complement words become zero).
module layer_transfer_sequencer #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DIM     = 26,
  parameter int unsigned NUM_CH  = 16,
  parameter int unsigned IDX_W   = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned RD_BASE = 0,
  parameter int unsigned WR_BASE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [IDX_W-1:0]           idx_x,
  output logic [IDX_W-1:0]           idx_y,
  output logic [IDX_W-1:0]           idx_ch,
  layer_transfer_sequencer_if.master mem
);

  localparam logic [IDX_W-1:0]  LP_X_MAX  = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0]  LP_Y_MAX  = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0]  LP_CH_MAX = IDX_W'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0] LP_RD_BASE = ADDR_W'(RD_BASE);
  localparam logic [ADDR_W-1:0] LP_WR_BASE = ADDR_W'(WR_BASE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic              r_wr_en;
  logic [IDX_W-1:0]  r_x;
  logic [IDX_W-1:0]  r_y;
  logic [IDX_W-1:0]  r_ch;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_clr_idx;
  logic              w_adv_idx;
  logic              w_cap;
  logic              w_last;
  logic              w_x_wrap;
  logic              w_y_wrap;
  logic [DATA_W-1:0] w_cap_data;

  // Element-position decode from the current indices
  always_comb begin
    w_x_wrap = (r_x == LP_X_MAX);
    w_y_wrap = (r_y == LP_Y_MAX);
    w_last   = w_x_wrap && w_y_wrap && (r_ch == LP_CH_MAX);
  end

  // Value loaded into the data register when leaving CAP
  always_comb begin
`ifdef LAYER_TRANSFER_RELU_EN
    w_cap_data = mem.rd_data[DATA_W-1] ? '0 : mem.rd_data;
`else
    w_cap_data = mem.rd_data;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    w_state_nxt = r_state;
    w_clr_idx   = 1'b0;
    w_adv_idx   = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clr_idx   = 1'b1;
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        w_state_nxt = S_CAP;
      end
      S_CAP: begin
        w_cap       = 1'b1;
        w_state_nxt = S_WR;
      end
      S_WR: begin
        if (mem.wr_ready) begin
          if (w_last) begin
            w_state_nxt = S_FIN;
          end else begin
            w_adv_idx   = 1'b1;
            w_state_nxt = S_RD;
          end
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Status and strobe outputs registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_FIN);
      r_rd_en <= (w_state_nxt == S_RD);
      r_wr_en <= (w_state_nxt == S_WR);
    end
  end

  // Index walk; addresses track the linear offset, which rises by one per element
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_ch      <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
    end else if (w_clr_idx) begin
      r_x       <= '0;
      r_y       <= '0;
      r_ch      <= '0;
      r_rd_addr <= LP_RD_BASE;
      r_wr_addr <= LP_WR_BASE;
    end else if (w_adv_idx) begin
      r_rd_addr <= r_rd_addr + ADDR_W'(1);
      r_wr_addr <= r_wr_addr + ADDR_W'(1);
      if (w_x_wrap) begin
        r_x <= '0;
        if (w_y_wrap) begin
          r_y  <= '0;
          r_ch <= r_ch + IDX_W'(1);
        end else begin
          r_y <= r_y + IDX_W'(1);
        end
      end else begin
        r_x <= r_x + IDX_W'(1);
      end
    end
  end

  // Data register: one cycle after the read strobe the source word is valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
    end else if (w_cap) begin
      r_data <= w_cap_data;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign idx_x       = r_x;
  assign idx_y       = r_y;
  assign idx_ch      = r_ch;
  assign mem.rd_en   = r_rd_en;
  assign mem.rd_addr = r_rd_addr;
  assign mem.wr_en   = r_wr_en;
  assign mem.wr_addr = r_wr_addr;
  assign mem.wr_data = r_data;

endmodule

// File: tb/tb_layer_transfer_sequencer.sv
// tb_layer_transfer_sequencer: randomized bench for layer_transfer_sequencer
// (DIM=3, NUM_CH=2, WR_BASE=100) with a transaction-level model of the copy.
module tb_layer_transfer_sequencer;

  localparam int N       = 18;
  localparam int DIM     = 3;
  localparam int NCH     = 2;
  localparam int RD_BASE = 0;
  localparam int WR_BASE = 100;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] idx_x;
  logic [15:0] idx_y;
  logic [15:0] idx_ch;

  layer_transfer_sequencer_if #(.DATA_W(64), .ADDR_W(16)) bus ();

  layer_transfer_sequencer #(
    .DATA_W(64), .DIM(DIM), .NUM_CH(NCH), .IDX_W(16), .ADDR_W(16),
    .RD_BASE(RD_BASE), .WR_BASE(WR_BASE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .idx_x(idx_x), .idx_y(idx_y), .idx_ch(idx_ch), .mem(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] src [0:63];

  // model state
  bit          m_active = 0;
  int          m_cyc, m_wcount, m_rcount, m_stalls;
  bit          prev_stall = 0;
  logic [15:0] prev_addr;
  logic [63:0] prev_data;
  int          done_count = 0;
  int          last_done_cyc = 0;
  int          last_done_g = 0;
  int          gcyc = 0;
  logic [15:0] wlog_addr [0:N-1];
  logic [63:0] wlog_data [0:N-1];
  logic [15:0] rlog_addr [0:N-1];
  logic [15:0] rlog_x [0:N-1];
  logic [15:0] rlog_y [0:N-1];
  logic [15:0] rlog_ch [0:N-1];

  int rdy_mode = 0;
  int hold_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_data(input int e);
`ifdef LAYER_TRANSFER_RELU_EN
    return src[e][63] ? 64'd0 : src[e];
`else
    return src[e];
`endif
  endfunction

  // source RAM: registered read, data valid the cycle after rd_en
  always @(posedge clk) begin
    logic        q_en;
    logic [15:0] q_addr;
    q_en   = bus.rd_en;
    q_addr = bus.rd_addr;
    #1;
    if (q_en) bus.rd_data = src[q_addr[5:0]];
  end

  // destination write-ready driver
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: bus.wr_ready = 1'b1;
      1: begin
        if (bus.wr_en && bus.wr_addr == 16'd105 && hold_left > 0) begin
          bus.wr_ready = 1'b0;
          hold_left--;
        end else begin
          bus.wr_ready = 1'b1;
        end
      end
      default: bus.wr_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // per-cycle comparison against the transfer model
  always @(negedge clk) begin
    int e;
    bit exp_done;
    gcyc++;
    if (reset) begin
      m_active   = 0;
      prev_stall = 0;
    end else if (m_active) begin
      m_cyc++;
      e = (m_wcount < N) ? m_wcount : N - 1;
      chk("busy", 64'(busy), 64'd1);
      chk("idx_x", 64'(idx_x), 64'(e % DIM));
      chk("idx_y", 64'(idx_y), 64'((e / DIM) % DIM));
      chk("idx_ch", 64'(idx_ch), 64'(e / (DIM * DIM)));
      chk("rd_addr", 64'(bus.rd_addr), 64'(RD_BASE + e));
      chk("wr_addr", 64'(bus.wr_addr), 64'(WR_BASE + e));
      exp_done = (m_cyc == 3 * N + 1 + m_stalls);
      chk("done", 64'(done), 64'(exp_done));
      if (exp_done) chk("done_all_written", 64'(m_wcount), 64'(N));
      if (bus.rd_en) begin
        chk("rd_wr_exclusive", 64'(bus.wr_en), 64'd0);
        chk("rd_order", 64'(m_rcount), 64'(m_wcount));
        if (m_rcount < N) begin
          rlog_addr[m_rcount] = bus.rd_addr;
          rlog_x[m_rcount]    = idx_x;
          rlog_y[m_rcount]    = idx_y;
          rlog_ch[m_rcount]   = idx_ch;
        end
        m_rcount++;
      end
      if (prev_stall) begin
        chk("stall_wr_en", 64'(bus.wr_en), 64'd1);
        chk("stall_wr_addr", 64'(bus.wr_addr), 64'(prev_addr));
        chk("stall_wr_data", bus.wr_data, prev_data);
      end
      if (bus.wr_en) begin
        chk("wr_after_rd", 64'(m_rcount), 64'(m_wcount + 1));
        if (bus.wr_ready) begin
          chk("wr_data", bus.wr_data, exp_data(e));
          if (m_wcount < N) begin
            wlog_addr[m_wcount] = bus.wr_addr;
            wlog_data[m_wcount] = bus.wr_data;
          end
          m_wcount++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_addr  = bus.wr_addr;
          prev_data  = bus.wr_data;
          m_stalls++;
        end
      end else begin
        prev_stall = 0;
      end
      if (exp_done) begin
        last_done_cyc = m_cyc;
        last_done_g   = gcyc;
        done_count++;
        m_active = 0;
      end
    end else begin
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_rd_en", 64'(bus.rd_en), 64'd0);
      chk("idle_wr_en", 64'(bus.wr_en), 64'd0);
      if (start) begin
        m_active = 1;
        m_cyc = 0; m_wcount = 0; m_rcount = 0; m_stalls = 0;
        prev_stall = 0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int d0;
    bit hit;
    d0  = done_count;
    hit = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (done_count != d0) begin hit = 1; break; end
    end
    chk(name, 64'(hit), 64'd1);
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 64; i++) src[i] = 64'(i + 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) src[i] = {$urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d0;
    int  g0;
    bit  hit;
    reset = 1'b1;
    start = 1'b0;
    bus.rd_data  = '0;
    bus.wr_ready = 1'b1;
    fill_linear();
    repeat (3) @(posedge clk);
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_en", 64'(bus.rd_en), 64'd0);
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_idx_x", 64'(idx_x), 64'd0);
    chk("rst_idx_ch", 64'(idx_ch), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", bus.wr_data, 64'd0);
    @(posedge clk); #2 reset = 1'b0;
    repeat (2) @(posedge clk);

    // basic copy
    rdy_mode = 0;
    pulse_start();
    wait_done("basic_done_seen", 200);
    chk("basic_done_cycle", 64'(last_done_cyc), 64'd55);
    chk("basic_first_addr", 64'(wlog_addr[0]), 64'd100);
    chk("basic_first_data", wlog_data[0], 64'd1);
    chk("basic_last_addr", 64'(wlog_addr[17]), 64'd117);
    chk("basic_last_data", wlog_data[17], 64'd18);
    // index wrap across channel boundary
    chk("wrap_prev_x", 64'(rlog_x[8]), 64'd2);
    chk("wrap_prev_y", 64'(rlog_y[8]), 64'd2);
    chk("wrap_prev_ch", 64'(rlog_ch[8]), 64'd0);
    chk("wrap_next_x", 64'(rlog_x[9]), 64'd0);
    chk("wrap_next_y", 64'(rlog_y[9]), 64'd0);
    chk("wrap_next_ch", 64'(rlog_ch[9]), 64'd1);
    chk("wrap_next_rd_addr", 64'(rlog_addr[9]), 64'd9);
    repeat (2) @(negedge clk);
    chk("final_idx_x", 64'(idx_x), 64'd2);
    chk("final_idx_y", 64'(idx_y), 64'd2);
    chk("final_idx_ch", 64'(idx_ch), 64'd1);
    chk("basic_busy_after", 64'(busy), 64'd0);

    // backpressure on element 5
    hold_left = 4;
    rdy_mode  = 1;
    pulse_start();
    wait_done("bp_done_seen", 200);
    chk("bp_done_cycle", 64'(last_done_cyc), 64'd59);
    chk("bp_stalls", 64'(m_stalls), 64'd4);
    chk("bp_elem5_addr", 64'(wlog_addr[5]), 64'd105);
    chk("bp_elem5_data", wlog_data[5], 64'd6);
    rdy_mode = 0;

    // start re-pulsed while busy
    d0 = done_count;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #3;
      if (m_active && m_wcount == 7) begin hit = 1; break; end
    end
    chk("busy_start_reach_e7", 64'(hit), 64'd1);
    pulse_start();
    wait_done("busy_start_done_seen", 200);
    repeat (10) @(negedge clk);
    chk("busy_start_one_done", 64'(done_count - d0), 64'd1);
    chk("busy_start_writes", 64'(m_wcount), 64'd18);

    // reset during WR of element 10
    fill_random();
    d0 = done_count;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #3;
      if (bus.wr_en && m_wcount == 10) begin hit = 1; break; end
    end
    chk("rst_mid_reach_e10", 64'(hit), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_idx_x", 64'(idx_x), 64'd0);
    chk("rst_mid_idx_y", 64'(idx_y), 64'd0);
    chk("rst_mid_idx_ch", 64'(idx_ch), 64'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_mid_no_done", 64'(done_count), 64'(d0));
    pulse_start();
    wait_done("rst_mid_restart_done", 200);
    chk("rst_mid_restart_writes", 64'(m_wcount), 64'd18);

    // sign handling of the copied word
    fill_linear();
    src[3] = 64'hFFFF_FFFF_FFFF_FFFE;
    src[4] = 64'h7;
    pulse_start();
    wait_done("relu_done_seen", 200);
    chk("relu_addr3", 64'(wlog_addr[3]), 64'd103);
`ifdef LAYER_TRANSFER_RELU_EN
    chk("relu_data3", wlog_data[3], 64'd0);
`else
    chk("relu_data3", wlog_data[3], 64'hFFFF_FFFF_FFFF_FFFE);
`endif
    chk("relu_data4", wlog_data[4], 64'h7);

    // randomized data and write backpressure
    rdy_mode = 2;
    for (int t = 0; t < 5; t++) begin
      fill_random();
      src[$urandom_range(0, N - 1)][63] = 1'b1;
      repeat ($urandom_range(0, 4)) @(posedge clk);
      pulse_start();
      wait_done("rand_done_seen", 400);
      chk("rand_writes", 64'(m_wcount), 64'd18);
    end

    // start held high: back-to-back transfers
    rdy_mode = 0;
    fill_random();
    @(posedge clk); #2 start = 1'b1;
    wait_done("b2b_first_done", 200);
    g0 = last_done_g;
    wait_done("b2b_second_done", 200);
    start = 1'b0;
    chk("b2b_done_cycle", 64'(last_done_cyc), 64'd55);
    chk("b2b_gap", 64'(last_done_g - g0), 64'd56);
    repeat (10) @(negedge clk);
    chk("b2b_idle_after", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_transfer_sequencer.md
Name: layer_transfer_sequencer

Overview:
- Moves one full feature-map volume (NUM_CH x DIM x DIM words) from the layer-1 output memory into the layer-2 input memory.
- Walks a 3-D index (x fastest, then y, then ch). Issues one read per element, then one write per element with write backpressure.
- Pulses done when the last write is accepted. The top-level scheduler uses this pulse to launch layer-2 compute.
- Sits between the layer-1 compute output RAM and the layer-2 input RAM, under control of the top-level scheduler FSM.

Parameters:
- DATA_W, 64, word width of the feature-map memories
- DIM, 26, spatial dimension (x and y each run 0..DIM-1)
- NUM_CH, 16, number of channels (ch runs 0..NUM_CH-1)
- IDX_W, 16, width of each index output
- ADDR_W, 16, width of read and write addresses
- RD_BASE, 0, base word address in the source memory
- WR_BASE, 0, base word address in the destination memory

Ports:
- clk, input, 1, single clock; all state updates on posedge
- reset, input, 1, asynchronous, active-high; clears all state
- start, input, 1, request a transfer; sampled only in IDLE
- busy, output, 1, high in every state except IDLE
- done, output, 1, one-cycle pulse after the final write is accepted
- rd_en, output, 1, source memory read strobe
- rd_addr, output, ADDR_W, source word address
- rd_data, input, DATA_W, source data; valid exactly one cycle after rd_en
- wr_en, output, 1, destination write request
- wr_addr, output, ADDR_W, destination word address
- wr_data, output, DATA_W, destination write data
- wr_ready, input, 1, a write is accepted on an edge where wr_en and wr_ready are both high
- idx_x, output, IDX_W, current element x index
- idx_y, output, IDX_W, current element y index
- idx_ch, output, IDX_W, current element channel index

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy, done, rd_en, wr_en = 0; idx_x, idx_y, idx_ch = 0; data register = 0; addresses = 0. Reset asserted mid-transfer aborts immediately. No partial write completes after reset asserts, and no done pulse is issued.
- Linear offset: off = idx_ch*DIM*DIM + idx_y*DIM + idx_x, computed at ADDR_W bits.
  - rd_addr = RD_BASE + off; wr_addr = WR_BASE + off.
  - Sums wrap modulo 2^ADDR_W.
  - rd_addr and wr_addr are always driven from the current indices.
- State IDLE:
  - busy=0.
  - start=1 on an edge: indices cleared to 0, go to RD.
  - start=0: stay in IDLE.
- State RD: rd_en=1 for exactly this cycle, then go to CAP.
- State CAP: capture rd_data into the data register on the edge leaving CAP, then go to WR.
- State WR:
  - wr_en=1; wr_data = data register. wr_en, wr_addr and wr_data stay stable while wr_ready=0.
  - On an accepting edge, if the element is not the last: advance the indices, go to RD.
  - Index advance: x+1. If x == DIM-1, then x=0 and y+1. If y also == DIM-1, then y=0 and ch+1.
  - On the accepting edge of the last element (x=DIM-1, y=DIM-1, ch=NUM_CH-1): indices are held, go to FIN.
- State FIN: done=1 for this cycle only, then go to IDLE.
- Latency with wr_ready tied high: 3 cycles per element.
  - Taking the start-sampling edge as edge 0, done is high during cycle 3*N+1, where N = NUM_CH*DIM*DIM.
  - Each wr_ready=0 cycle in WR adds one cycle.
- start while busy (including FIN) is ignored. No queuing; start must be re-asserted in IDLE.
- start held high continuously: a new transfer begins on the edge after FIN, i.e. back-to-back transfers.
- Indices never exceed DIM-1 / NUM_CH-1. After done, idx_* hold the final element's values until the next start.
- rd_en and wr_en are never high in the same cycle.

Optional Feature:
- Macro: LAYER_TRANSFER_RELU_EN.
- Defined: the data register is loaded with ReLU(rd_data), treating rd_data as signed two's-complement. If rd_data[DATA_W-1]=1 the register loads 0; otherwise it loads rd_data. Cycle timing is unchanged.
- Undefined: rd_data passes to wr_data unmodified.

Test Plan (all with DIM=3, NUM_CH=2, RD_BASE=0, WR_BASE=100, so N=18):
- Basic copy: source word i = i+1; start pulsed one cycle; wr_ready=1 -> 18 writes to addresses 100..117 with data 1..18 in order; done pulse in cycle 55; busy low afterwards.
- Backpressure: wr_ready low for 4 cycles on element 5 -> wr_en, wr_addr=105 and wr_data=6 held stable for those cycles; done in cycle 59; no duplicate or skipped writes.
- Index wrap: monitor indices -> after (x=2, y=2, ch=0) the next element is (0, 0, 1) with rd_addr=9; final indices are (2, 2, 1).
- Start while busy: start re-pulsed during element 7 -> ignored; exactly 18 writes and one done pulse.
- Reset mid-transfer: assert reset asynchronously during WR of element 10 -> wr_en, busy and idx_* drop to 0 immediately; no done; a later start copies all 18 from index 0.
- With LAYER_TRANSFER_RELU_EN defined: source word 3 = 0xFFFF_FFFF_FFFF_FFFE and word 4 = 0x7 -> write at 103 carries 0 and write at 104 carries 0x7. Without the macro: write at 103 carries 0xFFFF_FFFF_FFFF_FFFE.
